// File: rtl/xif_mac_coprocessor.sv
// CORE-V-XIF multiply/accumulate coprocessor: decodes custom-0 ops, holds them until commit,
// and executes them in order on a fixed-latency multiplier with a single accumulator.
module xif_mac_coprocessor #(
    parameter int unsigned ID_WIDTH = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned LATENCY  = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                x_issue_valid_i,
    output logic                x_issue_ready_o,
    input  logic [31:0]         x_issue_instr_i,
    input  logic [ID_WIDTH-1:0] x_issue_id_i,
    input  logic [31:0]         x_issue_rs0_i,
    input  logic [31:0]         x_issue_rs1_i,
    input  logic [1:0]          x_issue_rs_valid_i,
    output logic                x_issue_accept_o,
    output logic                x_issue_wb_o,
    input  logic                x_commit_valid_i,
    input  logic [ID_WIDTH-1:0] x_commit_id_i,
    input  logic                x_commit_kill_i,
    output logic                x_result_valid_o,
    input  logic                x_result_ready_i,
    output logic [ID_WIDTH-1:0] x_result_id_o,
    output logic [31:0]         x_result_data_o,
    output logic [4:0]          x_result_rd_o,
    output logic                x_result_we_o,
    output logic                busy_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [6:0]  OPC_CUSTOM0 = 7'b0001011;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [1:0]          op;
        logic [31:0]         rs0;
        logic [31:0]         rs1;
        logic [4:0]          rd;
        logic                committed;
        logic                killed;
    } entry_t;

    entry_t              queue_q [DEPTH];
    entry_t              queue_d [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d, scan_idx;
    logic [CNT_W-1:0]    count_q, count_d;
    state_e              state_q, state_d;
    logic [LAT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         acc_q, acc_d;
    logic                res_valid_q, res_valid_d;
    logic                res_we_q, res_we_d;
    logic [ID_WIDTH-1:0] res_id_q, res_id_d;
    logic [31:0]         res_data_q, res_data_d;
    logic [4:0]          res_rd_q, res_rd_d;
    logic                busy_q, busy_d;

    logic                decoded_c, push_c, pop_c, commit_hit_c;
    entry_t              head_c;
    logic [31:0]         prod_c;
    logic                unused_instr_bits;

    assign unused_instr_bits = ^x_issue_instr_i[31:15];

    // Issue decode and handshake; non-custom instructions are always waved through unaccepted.
    always_comb begin
        decoded_c        = (x_issue_instr_i[6:0] == OPC_CUSTOM0) && !x_issue_instr_i[14];
        x_issue_ready_o  = 1'b1;
        if (decoded_c) begin
            x_issue_ready_o = (x_issue_rs_valid_i == 2'b11) && (count_q < CNT_W'(DEPTH));
        end
        x_issue_accept_o = decoded_c;
        x_issue_wb_o     = decoded_c;
        push_c           = x_issue_valid_i && x_issue_ready_o && decoded_c;
    end

    // Queue write and commit/kill marking of the oldest open entry with a matching id.
    always_comb begin
        queue_d      = queue_q;
        commit_hit_c = 1'b0;
        scan_idx     = '0;
        if (push_c) begin
            queue_d[tail_q].id        = x_issue_id_i;
            queue_d[tail_q].op        = x_issue_instr_i[13:12];
            queue_d[tail_q].rs0       = x_issue_rs0_i;
            queue_d[tail_q].rs1       = x_issue_rs1_i;
            queue_d[tail_q].rd        = x_issue_instr_i[11:7];
            queue_d[tail_q].committed = 1'b0;
            queue_d[tail_q].killed    = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (x_commit_valid_i && !commit_hit_c &&
                ((CNT_W'(i) < count_q) || (push_c && (CNT_W'(i) == count_q))) &&
                (queue_d[scan_idx].id == x_commit_id_i) &&
                !queue_d[scan_idx].committed && !queue_d[scan_idx].killed) begin
                commit_hit_c = 1'b1;
                if (x_commit_kill_i) begin
                    queue_d[scan_idx].killed = 1'b1;
                end else begin
                    queue_d[scan_idx].committed = 1'b1;
                end
            end
        end
    end

    // In-order execution FSM working on the queue head.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        res_valid_d = res_valid_q;
        res_we_d    = res_we_q;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        pop_c       = 1'b0;
        head_c      = queue_q[head_q];
        prod_c      = head_c.rs0 * head_c.rs1;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    if (head_c.killed) begin
                        pop_c = 1'b1;
                    end else if (head_c.committed) begin
                        state_d = EXEC;
                        cnt_d   = LAT_W'(LATENCY - 1);
                    end
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d     = RESP;
                    res_valid_d = 1'b1;
                    res_we_d    = 1'b1;
                    res_id_d    = head_c.id;
                    res_rd_d    = head_c.rd;
                    case (head_c.op)
                        2'd0: res_data_d = prod_c;
                        2'd1: begin
                            acc_d      = acc_q + prod_c;
                            res_data_d = acc_q + prod_c;
                        end
                        2'd2: res_data_d = acc_q;
                        default: begin
                            acc_d      = '0;
                            res_data_d = '0;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (x_result_ready_i) begin
                    pop_c       = 1'b1;
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                    res_we_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        head_d  = pop_c  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push_c ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        busy_d  = (count_d != '0) || (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                queue_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
            res_we_q    <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            queue_q     <= queue_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            res_valid_q <= res_valid_d;
            res_we_q    <= res_we_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
            busy_q      <= busy_d;
        end
    end

    assign x_result_valid_o = res_valid_q;
    assign x_result_we_o    = res_we_q;
    assign x_result_id_o    = res_id_q;
    assign x_result_data_o  = res_data_q;
    assign x_result_rd_o    = res_rd_q;
    assign busy_o           = busy_q;

endmodule
